// File: rtl/sample_checker.sv
// sample_checker: captures one video frame into an external RAM, reads it back,
// and compares additive checksums of the written and read-back words.
//
// Ports
//   clk            system clock, every register updates on its rising edge
//   rst            synchronous active-high reset
//   pixel_clock    video pixel clock, treated as data and synchronised
//   r, g, b        colour components, sampled on synchronised pixel_clock rise
//   hsync, vsync   active-high sync pulses, synchronised
//   start_button   active-high start request, synchronised and edge detected
//   internal_state FSM state (IDLE=0 .. FAIL=6)
//   addr           RAM word address
//   rw             RAM command, 1=write 0=read
//   data_in        write data to RAM
//   data_out       read data from RAM
//   busy           RAM cannot accept a command
//   in_valid       one-cycle command strobe
//   out_valid      one-cycle read-data strobe
//   leds           [0] capturing, [1] reading back, [2] pass, [3] fail
module sample_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_clock,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        start_button,
  output logic [2:0]  internal_state,
  output logic [22:0] addr,
  output logic        rw,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  input  logic        busy,
  output logic        in_valid,
  input  logic        out_valid,
  output logic [3:0]  leds
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VSYNC = 3'd1,
    CAPTURE    = 3'd2,
    READBACK   = 3'd3,
    WAIT_READ  = 3'd4,
    PASS       = 3'd5,
    FAIL       = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  leds_q;
  logic [22:0] addr_q;
  logic [22:0] n_q;
  logic        rw_q;
  logic [31:0] data_in_q;
  logic        in_valid_q;
  logic [31:0] wsum_q;
  logic [31:0] rsum_q;
  logic        pend_q;
  logic [31:0] pend_data_q;
  logic        ovf_q;
  logic        end_q;

  // Synchroniser bit order: {start_button, vsync, hsync, pixel_clock}.
  // meta -> sync is the 2-flop synchroniser, prev holds the previous
  // synchronised value for edge detection.
  logic [3:0]  meta_q, sync_q, prev_q;

  logic pix_rise, hs_s, vs_s, vs_rise, vs_fall, start_rise;
  logic sample_evt, wr_issue, cap_done, rb_cmp, rb_issue, sums_ok, rd_accept;

  assign pix_rise   = sync_q[0] & ~prev_q[0];
  assign hs_s       = sync_q[1];
  assign vs_s       = sync_q[2];
  assign vs_rise    = sync_q[2] & ~prev_q[2];
  assign vs_fall    = ~sync_q[2] & prev_q[2];
  assign start_rise = sync_q[3] & ~prev_q[3];

  assign sample_evt = pix_rise & ~hs_s & ~vs_s;

  // A write is held back while the previous strobe is still high so that
  // in_valid never stays high two cycles in a row; the address advances
  // on the cycle after the strobe.
  assign wr_issue = (state_q == CAPTURE) & pend_q & ~busy & ~in_valid_q
                  & (addr_q != '1);

  // Frame end waits until any queued write has been issued and its
  // address increment has landed, so N equals the number of writes.
  assign cap_done = (state_q == CAPTURE) & ~in_valid_q
                  & ((addr_q == '1) | ((end_q | vs_rise) & ~pend_q));

  assign rb_cmp    = (state_q == READBACK) & (addr_q == n_q);
  assign rb_issue  = (state_q == READBACK) & ~rb_cmp & ~busy;
  assign sums_ok   = (wsum_q == rsum_q) & ~ovf_q;
  assign rd_accept = (state_q == WAIT_READ) & out_valid & ~in_valid_q;

  function automatic logic [3:0] leds_of(input state_t s);
    logic [3:0] l;
    l = '0;
    case (s)
      WAIT_VSYNC, CAPTURE: l[0] = 1'b1;
      READBACK, WAIT_READ: l[1] = 1'b1;
      PASS:                l[2] = 1'b1;
      FAIL:                l[3] = 1'b1;
      default:             l    = '0;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_rise) state_d = WAIT_VSYNC;
      WAIT_VSYNC: if (vs_fall)    state_d = CAPTURE;
      CAPTURE:    if (cap_done)   state_d = READBACK;
      READBACK: begin
        if (rb_cmp)        state_d = sums_ok ? PASS : FAIL;
        else if (rb_issue) state_d = WAIT_READ;
      end
      WAIT_READ:  if (rd_accept)  state_d = READBACK;
      PASS, FAIL: if (start_rise) state_d = WAIT_VSYNC;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      leds_q      <= '0;
      addr_q      <= '0;
      n_q         <= '0;
      rw_q        <= 1'b0;
      data_in_q   <= '0;
      in_valid_q  <= 1'b0;
      wsum_q      <= '0;
      rsum_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
      end_q       <= 1'b0;
      meta_q      <= '0;
      sync_q      <= '0;
      prev_q      <= '0;
    end else begin
      meta_q     <= {start_button, vsync, hsync, pixel_clock};
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      state_q    <= state_d;
      leds_q     <= leds_of(state_d);
      in_valid_q <= 1'b0;

      case (state_q)
        WAIT_VSYNC: begin
          if (vs_fall) begin
            addr_q <= '0;
            wsum_q <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            end_q  <= 1'b0;
          end
        end

        CAPTURE: begin
          if (vs_rise)    end_q  <= 1'b1;
          if (in_valid_q) addr_q <= addr_q + 23'd1;

          if (wr_issue) begin
            in_valid_q <= 1'b1;
            rw_q       <= 1'b1;
            data_in_q  <= pend_data_q;
            pend_q     <= 1'b0;
            wsum_q     <= wsum_q + pend_data_q;
          end

          // pend_q is only written here when clear and by wr_issue only
          // when set, so the two branches never collide.
          if (sample_evt) begin
            if (pend_q) begin
              ovf_q <= 1'b1;
            end else begin
              pend_q      <= 1'b1;
              pend_data_q <= {8'h00, r, g, b};
            end
          end

          if (cap_done) begin
            n_q    <= addr_q;
            addr_q <= '0;
            rsum_q <= '0;
          end
        end

        READBACK: begin
          if (rb_issue) begin
            in_valid_q <= 1'b1;
            rw_q       <= 1'b0;
          end
        end

        WAIT_READ: begin
          if (rd_accept) begin
            rsum_q <= rsum_q + data_out;
            addr_q <= addr_q + 23'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign internal_state = state_q;
  assign addr           = addr_q;
  assign rw             = rw_q;
  assign data_in        = data_in_q;
  assign in_valid       = in_valid_q;
  assign leds           = leds_q;

endmodule

// File: tb/tb_sample_checker.sv
`timescale 1ns/1ns
module tb_sample_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_clock;
  logic [7:0]  r, g, b;
  logic        hsync, vsync;
  logic        start_button;
  logic [2:0]  internal_state;
  logic [22:0] addr;
  logic        rw;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        in_valid;
  logic        out_valid;
  logic [3:0]  leds;

  always #1 clk = ~clk;

  sample_checker dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_clock    (pixel_clock),
    .r              (r),
    .g              (g),
    .b              (b),
    .hsync          (hsync),
    .vsync          (vsync),
    .start_button   (start_button),
    .internal_state (internal_state),
    .addr           (addr),
    .rw             (rw),
    .data_in        (data_in),
    .data_out       (data_out),
    .busy           (busy),
    .in_valid       (in_valid),
    .out_valid      (out_valid),
    .leds           (leds)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel stimulus and the words the checker must write for it.
  logic [23:0] pix_tab [6] = '{24'h102030, 24'hFFFFFF, 24'h000000,
                               24'hA5C35A, 24'h0F00F0, 24'h123456};
  logic [31:0] exp_word [6] = '{32'h00102030, 32'h00FFFFFF, 32'h00000000,
                                32'h00A5C35A, 32'h000F00F0, 32'h00123456};

  // RAM model and bus monitor
  logic [31:0] mem [logic [22:0]];
  logic [22:0] wr_a [$];
  logic [31:0] wr_d [$];
  logic [22:0] rd_a [$];
  int          inv_cnt = 0;
  logic        inv_run_err = 1'b0;
  logic        prev_inv = 1'b0;
  int          rd_pend = 0;
  logic [31:0] rd_data = '0;
  logic        corrupt = 1'b0;
  logic [22:0] corrupt_addr = 23'd2;

  always @(negedge clk) begin
    out_valid = 1'b0;
    if (in_valid) begin
      inv_cnt++;
      if (prev_inv) inv_run_err = 1'b1;
      if (rw) begin
        mem[addr] = data_in;
        wr_a.push_back(addr);
        wr_d.push_back(data_in);
      end else begin
        rd_a.push_back(addr);
        rd_data = mem.exists(addr) ? mem[addr] : 32'h0;
        if (corrupt && addr == corrupt_addr) rd_data = rd_data ^ 32'h0000_0100;
        rd_pend = 3;
      end
    end
    prev_inv = in_valid;
    if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        out_valid = 1'b1;
        data_out  = rd_data;
      end
    end
  end

  task automatic pix(input logic [23:0] rgb, input logic hs, input logic vs);
    pixel_clock = 1'b0;
    {r, g, b}   = rgb;
    hsync       = hs;
    vsync       = vs;
    #10;
    pixel_clock = 1'b1;
    #10;
  endtask

  // Two vsync-high pixels, vsync falls on a blanking (hsync) pixel, nact
  // active pixels in lines of three, then vsync rises again.
  task automatic frame(input int nact, input bit chk_cap);
    pix(24'h0, 1'b0, 1'b1);
    pix(24'h0, 1'b0, 1'b1);
    pix(24'h0, 1'b1, 1'b0);
    if (chk_cap) check("cap_state", internal_state, 3'd2);
    for (int i = 0; i < nact; i++) begin
      if (i != 0 && i % 3 == 0) pix(24'h0, 1'b1, 1'b0);
      pix(pix_tab[i], 1'b0, 1'b0);
    end
    pix(24'h0, 1'b1, 1'b0);
    pix(24'h0, 1'b0, 1'b1);
    pix(24'h0, 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!(internal_state == 3'd5 || internal_state == 3'd6) && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic press_start();
    start_button = 1'b0;
    repeat (6) @(negedge clk);
    start_button = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; pixel_clock = 1'b0; r = '0; g = '0; b = '0;
    hsync = 1'b0; vsync = 1'b1; start_button = 1'b0; busy = 1'b0;
    out_valid = 1'b0; data_out = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",    internal_state, 3'd0);
    check("rst_addr",     addr,           23'd0);
    check("rst_rw",       rw,             1'b0);
    check("rst_data_in",  data_in,        32'd0);
    check("rst_in_valid", in_valid,       1'b0);
    check("rst_leds",     leds,           4'b0000);
    rst = 1'b0;

    // Video running without a start request
    base = inv_cnt;
    frame(6, 1'b0);
    frame(6, 1'b0);
    check("nostart_state", internal_state, 3'd0);
    check("nostart_pulses", inv_cnt - base, 0);

    // Capture and passing readback
    clear_logs();
    press_start();
    check("wv_state", internal_state, 3'd1);
    check("wv_leds",  leds,           4'b0001);
    frame(6, 1'b1);
    wait_done();
    check("cap_nwr", wr_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wr_addr%0d", i), (i < wr_a.size()) ? wr_a[i] : 23'h7FFFFF, i);
      check($sformatf("wr_data%0d", i), (i < wr_d.size()) ? wr_d[i] : 32'hDEAD_BEEF, exp_word[i]);
    end
    check("rb_nrd", rd_a.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rd_addr%0d", i), (i < rd_a.size()) ? rd_a[i] : 23'h7FFFFF, i);
    check("pass_state", internal_state, 3'd5);
    check("pass_leds",  leds,           4'b0100);

    // Corrupted readback word
    clear_logs();
    press_start();
    check("restart1_state", internal_state, 3'd1);
    check("restart1_leds",  leds,           4'b0001);
    corrupt = 1'b1;
    frame(6, 1'b0);
    wait_done();
    corrupt = 1'b0;
    check("bad_nrd",   rd_a.size(),    6);
    check("bad_state", internal_state, 3'd6);
    check("bad_leds",  leds,           4'b1000);

    // Overflow: RAM busy across several pixel edges
    clear_logs();
    press_start();
    check("restart2_state", internal_state, 3'd1);
    busy = 1'b1;
    frame(6, 1'b0);
    busy = 1'b0;
    wait_done();
    check("ovf_nwr",   wr_a.size(), 1);
    check("ovf_wdata", (wr_d.size() > 0) ? wr_d[0] : 32'hDEAD_BEEF, 32'h00102030);
    check("ovf_state", internal_state, 3'd6);
    check("ovf_leds",  leds,           4'b1000);
    press_start();
    check("restart3_state", internal_state, 3'd1);
    check("restart3_leds32", leds[3:2], 2'b00);

    // Empty frame
    clear_logs();
    frame(0, 1'b0);
    wait_done();
    check("empty_nwr",   wr_a.size(),    0);
    check("empty_state", internal_state, 3'd5);
    check("empty_leds",  leds,           4'b0100);

    check("inv_run", inv_run_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
